// File: rtl/mvu_cfg_pkg.sv
// Shared definitions for the MVU APB configuration register file:
// register map, field positions and the grouped configuration struct.
package mvu_cfg_pkg;

  localparam logic [31:0] ID_VALUE = 32'h4D56_5501;

  localparam logic [7:0] CTRL_OFS      = 8'h00;
  localparam logic [7:0] STATUS_OFS    = 8'h04;
  localparam logic [7:0] PREC_OFS      = 8'h08;
  localparam logic [7:0] QUANT_OFS     = 8'h0C;
  localparam logic [7:0] COUNTDOWN_OFS = 8'h10;
  localparam logic [7:0] WBASE_OFS     = 8'h14;
  localparam logic [7:0] IBASE_OFS     = 8'h18;
  localparam logic [7:0] OBASE_OFS     = 8'h1C;
  localparam logic [7:0] SCALER_OFS    = 8'h20;
  localparam logic [7:0] BIAS_OFS      = 8'h24;
  localparam logic [7:0] ID_OFS        = 8'h28;

  localparam int NUM_REGS = 11;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_IRQ_EN_BIT  = 1;
  localparam int CTRL_RELU_EN_BIT = 2;
  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_DONE_BIT  = 1;
  localparam int PREC_W           = 6;
  localparam int PREC_WPREC_LSB   = 0;
  localparam int PREC_IPREC_LSB   = 6;
  localparam int PREC_OPREC_LSB   = 12;
  localparam int PREC_ISIGN_BIT   = 18;
  localparam int PREC_WSIGN_BIT   = 19;
  localparam int QUANT_MSB_LSB    = 0;

  // Word index of each register (byte offset / 4).
  typedef enum logic [3:0] {
    REG_CTRL      = CTRL_OFS[5:2],
    REG_STATUS    = STATUS_OFS[5:2],
    REG_PREC      = PREC_OFS[5:2],
    REG_QUANT     = QUANT_OFS[5:2],
    REG_COUNTDOWN = COUNTDOWN_OFS[5:2],
    REG_WBASE     = WBASE_OFS[5:2],
    REG_IBASE     = IBASE_OFS[5:2],
    REG_OBASE     = OBASE_OFS[5:2],
    REG_SCALER    = SCALER_OFS[5:2],
    REG_BIAS      = BIAS_OFS[5:2],
    REG_ID        = ID_OFS[5:2]
  } reg_e;

  typedef struct packed {
    logic        relu_en;
    logic [5:0]  wprec;
    logic [5:0]  iprec;
    logic [5:0]  oprec;
    logic        isign;
    logic        wsign;
    logic [5:0]  quant_msb;
    logic [31:0] countdown;
    logic [31:0] wbase;
    logic [31:0] ibase;
    logic [31:0] obase;
    logic [31:0] scaler;
    logic [31:0] bias;
  } mvu_cfg_t;

endpackage

// File: rtl/mvu_apb_cfg_regs_apb_slave_if.sv
// APB access strobe and register-index decode; byte lanes below the word
// boundary are ignored.
module apb_slave_if
  import mvu_cfg_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  output logic                  access,
  output logic                  wr_en,
  output logic                  hit,
  output reg_e                  reg_idx
);

  localparam int WORD_W = ADDR_WIDTH - 2;

  logic [WORD_W-1:0] w_word;
  logic [1:0]        w_unused_lsb;

  assign w_word       = paddr[ADDR_WIDTH-1:2];
  assign w_unused_lsb = paddr[1:0];

  assign access  = psel & penable;
  assign wr_en   = psel & penable & pwrite;
  assign hit     = (w_word < WORD_W'(NUM_REGS));
  assign reg_idx = reg_e'(w_word[3:0]);

endmodule

// File: rtl/mvu_apb_cfg_regs.sv
// APB3 register file holding one MVU job configuration; issues the start
// pulse, tracks sticky done and raises irq on completion.
module mvu_apb_cfg_regs
  import mvu_cfg_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] ID_VALUE   = mvu_cfg_pkg::ID_VALUE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic                  mvu_busy,
  input  logic                  mvu_done,
  output logic                  cfg_start,
  output logic                  cfg_relu_en,
  output logic [5:0]            cfg_wprec,
  output logic [5:0]            cfg_iprec,
  output logic [5:0]            cfg_oprec,
  output logic                  cfg_isign,
  output logic                  cfg_wsign,
  output logic [5:0]            cfg_quant_msb,
  output logic [31:0]           cfg_countdown,
  output logic [31:0]           cfg_wbase,
  output logic [31:0]           cfg_ibase,
  output logic [31:0]           cfg_obase,
  output logic [31:0]           cfg_scaler,
  output logic [31:0]           cfg_bias,
  output logic                  irq
);

  logic     w_access;
  logic     w_wr_en;
  logic     w_hit;
  reg_e     w_reg_idx;
  logic     w_wr_ok;
  logic     w_start_req;
  logic     w_start_blocked;
  logic     w_done_clr;
  logic [DATA_WIDTH-1:0] w_rdata;

  mvu_cfg_t r_cfg;
  logic     r_irq_en;
  logic     r_done;
  logic     r_start;

  apb_slave_if #(.ADDR_WIDTH(ADDR_WIDTH)) u_apb_if (
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .access  (w_access),
    .wr_en   (w_wr_en),
    .hit     (w_hit),
    .reg_idx (w_reg_idx)
  );

  assign w_wr_ok         = w_wr_en & w_hit;
  assign w_start_req     = w_wr_ok & (w_reg_idx == REG_CTRL) & pwdata[CTRL_START_BIT];
  assign w_start_blocked = w_start_req & mvu_busy;
  assign w_done_clr      = w_wr_ok & (w_reg_idx == REG_STATUS) & pwdata[STATUS_DONE_BIT];

  assign pready  = 1'b1;
  assign pslverr = w_access & (~w_hit
                               | (pwrite & (w_reg_idx == REG_ID))
                               | w_start_blocked);

  always_comb begin
    w_rdata = '0;
    if (w_hit) begin
      case (w_reg_idx)
        REG_CTRL: begin
          w_rdata[CTRL_IRQ_EN_BIT]  = r_irq_en;
          w_rdata[CTRL_RELU_EN_BIT] = r_cfg.relu_en;
        end
        REG_STATUS: begin
          w_rdata[STATUS_BUSY_BIT] = mvu_busy;
          w_rdata[STATUS_DONE_BIT] = r_done;
        end
        REG_PREC: begin
          w_rdata[PREC_WPREC_LSB +: PREC_W] = r_cfg.wprec;
          w_rdata[PREC_IPREC_LSB +: PREC_W] = r_cfg.iprec;
          w_rdata[PREC_OPREC_LSB +: PREC_W] = r_cfg.oprec;
          w_rdata[PREC_ISIGN_BIT]           = r_cfg.isign;
          w_rdata[PREC_WSIGN_BIT]           = r_cfg.wsign;
        end
        REG_QUANT:     w_rdata[QUANT_MSB_LSB +: PREC_W] = r_cfg.quant_msb;
        REG_COUNTDOWN: w_rdata = r_cfg.countdown;
        REG_WBASE:     w_rdata = r_cfg.wbase;
        REG_IBASE:     w_rdata = r_cfg.ibase;
        REG_OBASE:     w_rdata = r_cfg.obase;
        REG_SCALER:    w_rdata = r_cfg.scaler;
        REG_BIAS:      w_rdata = r_cfg.bias;
        REG_ID:        w_rdata = ID_VALUE;
        default:       w_rdata = '0;
      endcase
    end
  end

  assign prdata = psel ? w_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg    <= '0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_start  <= 1'b0;
    end else begin
      r_start <= w_start_req & ~mvu_busy;
      if (w_wr_ok) begin
        case (w_reg_idx)
          REG_CTRL: begin
            r_irq_en      <= pwdata[CTRL_IRQ_EN_BIT];
            r_cfg.relu_en <= pwdata[CTRL_RELU_EN_BIT];
          end
          REG_PREC: begin
            r_cfg.wprec <= pwdata[PREC_WPREC_LSB +: PREC_W];
            r_cfg.iprec <= pwdata[PREC_IPREC_LSB +: PREC_W];
            r_cfg.oprec <= pwdata[PREC_OPREC_LSB +: PREC_W];
            r_cfg.isign <= pwdata[PREC_ISIGN_BIT];
            r_cfg.wsign <= pwdata[PREC_WSIGN_BIT];
          end
          REG_QUANT:     r_cfg.quant_msb <= pwdata[QUANT_MSB_LSB +: PREC_W];
          REG_COUNTDOWN: r_cfg.countdown <= pwdata;
          REG_WBASE:     r_cfg.wbase     <= pwdata;
          REG_IBASE:     r_cfg.ibase     <= pwdata;
          REG_OBASE:     r_cfg.obase     <= pwdata;
          REG_SCALER:    r_cfg.scaler    <= pwdata;
          REG_BIAS:      r_cfg.bias      <= pwdata;
          default: ;
        endcase
      end
      // A completion in the same cycle as a clear must not be lost.
      if (mvu_done) begin
        r_done <= 1'b1;
      end else if (w_done_clr) begin
        r_done <= 1'b0;
      end
    end
  end

  assign cfg_start     = r_start;
  assign cfg_relu_en   = r_cfg.relu_en;
  assign cfg_wprec     = r_cfg.wprec;
  assign cfg_iprec     = r_cfg.iprec;
  assign cfg_oprec     = r_cfg.oprec;
  assign cfg_isign     = r_cfg.isign;
  assign cfg_wsign     = r_cfg.wsign;
  assign cfg_quant_msb = r_cfg.quant_msb;
  assign cfg_countdown = r_cfg.countdown;
  assign cfg_wbase     = r_cfg.wbase;
  assign cfg_ibase     = r_cfg.ibase;
  assign cfg_obase     = r_cfg.obase;
  assign cfg_scaler    = r_cfg.scaler;
  assign cfg_bias      = r_cfg.bias;
  assign irq           = r_done & r_irq_en;

endmodule

// File: tb/tb_mvu_apb_cfg_regs.sv
// Bench for mvu_apb_cfg_regs: table of APB vectors with a scoreboard queue,
// plus hand sequences for start/done/irq, same-cycle set/clear and reset.
module tb_mvu_apb_cfg_regs;

  localparam logic [31:0] ID_EXP = 32'h4D56_5501;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        mvu_busy, mvu_done;
  logic        cfg_start, cfg_relu_en, cfg_isign, cfg_wsign;
  logic [5:0]  cfg_wprec, cfg_iprec, cfg_oprec, cfg_quant_msb;
  logic [31:0] cfg_countdown, cfg_wbase, cfg_ibase, cfg_obase, cfg_scaler, cfg_bias;
  logic        irq;

  always #5 clk = ~clk;

  mvu_apb_cfg_regs dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .mvu_busy(mvu_busy), .mvu_done(mvu_done),
    .cfg_start(cfg_start), .cfg_relu_en(cfg_relu_en), .cfg_wprec(cfg_wprec),
    .cfg_iprec(cfg_iprec), .cfg_oprec(cfg_oprec), .cfg_isign(cfg_isign),
    .cfg_wsign(cfg_wsign), .cfg_quant_msb(cfg_quant_msb),
    .cfg_countdown(cfg_countdown), .cfg_wbase(cfg_wbase), .cfg_ibase(cfg_ibase),
    .cfg_obase(cfg_obase), .cfg_scaler(cfg_scaler), .cfg_bias(cfg_bias), .irq(irq)
  );

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        chk_rd;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic void addv(input logic wr, input logic [11:0] a, input logic [31:0] d,
                               input logic b, input logic [31:0] r, input logic e);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.busy = b; v.exp_rd = r; v.exp_err = e;
    vecs.push_back(v);
  endfunction

  task automatic sb_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb_q.pop_front();
      if (e.chk_rd) check({e.name, " prdata"}, prdata, e.rd);
      check({e.name, " pslverr"}, {31'b0, pslverr}, {31'b0, e.err});
    end
  endtask

  task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_err, input string nm);
    exp_t e;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    e.rd = exp_rd; e.err = exp_err; e.chk_rd = !wr; e.name = nm;
    sb_q.push_back(e);
    @(negedge clk);
    sb_pop();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; mvu_busy = 1'b0; mvu_done = 1'b0;

    // reset image, unimplemented bits, full registers, error decode
    for (int a = 0; a <= 'h24; a += 4) addv(1'b0, 12'(a), 32'h0, 1'b0, 32'h0, 1'b0);
    addv(1'b0, 12'h028, 32'h0,         1'b0, ID_EXP,        1'b0);
    addv(1'b1, 12'h008, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0);
    addv(1'b0, 12'h008, 32'h0,         1'b0, 32'h000F_FFFF, 1'b0);
    addv(1'b1, 12'h00C, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0);
    addv(1'b0, 12'h00C, 32'h0,         1'b0, 32'h0000_003F, 1'b0);
    addv(1'b1, 12'h008, 32'h000C_2082, 1'b0, 32'h0,         1'b0);
    addv(1'b0, 12'h008, 32'h0,         1'b0, 32'h000C_2082, 1'b0);
    addv(1'b0, 12'h00B, 32'h0,         1'b0, 32'h000C_2082, 1'b0);
    addv(1'b1, 12'h010, 32'h0000_1000, 1'b0, 32'h0,         1'b0);
    addv(1'b1, 12'h014, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0);
    addv(1'b1, 12'h018, 32'h1111_2222, 1'b0, 32'h0,         1'b0);
    addv(1'b1, 12'h01C, 32'h3333_4444, 1'b0, 32'h0,         1'b0);
    addv(1'b1, 12'h020, 32'h5555_6666, 1'b0, 32'h0,         1'b0);
    addv(1'b1, 12'h024, 32'h8000_0001, 1'b0, 32'h0,         1'b0);
    addv(1'b0, 12'h010, 32'h0,         1'b0, 32'h0000_1000, 1'b0);
    addv(1'b0, 12'h014, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0);
    addv(1'b0, 12'h018, 32'h0,         1'b0, 32'h1111_2222, 1'b0);
    addv(1'b0, 12'h01C, 32'h0,         1'b0, 32'h3333_4444, 1'b0);
    addv(1'b0, 12'h020, 32'h0,         1'b0, 32'h5555_6666, 1'b0);
    addv(1'b0, 12'h024, 32'h0,         1'b0, 32'h8000_0001, 1'b0);
    addv(1'b1, 12'h000, 32'h0000_0006, 1'b0, 32'h0,         1'b0);
    addv(1'b0, 12'h000, 32'h0,         1'b0, 32'h0000_0006, 1'b0);
    addv(1'b1, 12'h004, 32'hFFFF_FFFD, 1'b0, 32'h0,         1'b0);
    addv(1'b0, 12'h004, 32'h0,         1'b1, 32'h0000_0001, 1'b0);
    addv(1'b0, 12'h100, 32'h0,         1'b0, 32'h0,         1'b1);
    addv(1'b1, 12'h100, 32'h1234_5678, 1'b0, 32'h0,         1'b1);
    addv(1'b1, 12'h028, 32'h0000_0000, 1'b0, 32'h0,         1'b1);
    addv(1'b0, 12'h028, 32'h0,         1'b0, ID_EXP,        1'b0);
    addv(1'b1, 12'h02C, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b1);
    addv(1'b0, 12'h02C, 32'h0,         1'b0, 32'h0,         1'b1);
    addv(1'b0, 12'hFFC, 32'h0,         1'b0, 32'h0,         1'b1);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset irq",       {31'b0, irq},       32'h0);
    check("reset cfg_start", {31'b0, cfg_start}, 32'h0);
    check("idle prdata",     prdata,             32'h0);
    check("pready",          {31'b0, pready},    32'h1);

    for (int i = 0; i < vecs.size(); i++) begin
      mvu_busy = vecs[i].busy;
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err,
          $sformatf("vec%0d@%03h", i, vecs[i].addr));
      mvu_busy = 1'b0;
    end

    @(negedge clk);
    check("cfg_wprec",     {26'b0, cfg_wprec},     32'd2);
    check("cfg_iprec",     {26'b0, cfg_iprec},     32'd2);
    check("cfg_oprec",     {26'b0, cfg_oprec},     32'd2);
    check("cfg_isign",     {31'b0, cfg_isign},     32'd1);
    check("cfg_wsign",     {31'b0, cfg_wsign},     32'd1);
    check("cfg_quant_msb", {26'b0, cfg_quant_msb}, 32'h3F);
    check("cfg_countdown", cfg_countdown,          32'h0000_1000);
    check("cfg_ibase",     cfg_ibase,              32'h1111_2222);
    check("cfg_obase",     cfg_obase,              32'h3333_4444);
    check("cfg_scaler",    cfg_scaler,             32'h5555_6666);
    check("cfg_bias",      cfg_bias,               32'h8000_0001);
    check("cfg_relu_en",   {31'b0, cfg_relu_en},   32'd1);
    check("irq no done",   {31'b0, irq},           32'h0);

    // cfg output follows the write on the next cycle
    check("cfg_wbase old", cfg_wbase, 32'hDEAD_BEEF);
    apb(1'b1, 12'h014, 32'h1234_5678, 32'h0, 1'b0, "wbase wr");
    @(negedge clk);
    check("cfg_wbase new", cfg_wbase, 32'h1234_5678);

    // start pulse, done, irq, W1C
    apb(1'b1, 12'h000, 32'h7, 32'h0, 1'b0, "ctrl start");
    @(negedge clk);
    check("start pulse hi",  {31'b0, cfg_start}, 32'h1);
    @(negedge clk);
    check("start pulse lo",  {31'b0, cfg_start}, 32'h0);
    apb(1'b0, 12'h000, 32'h0, 32'h6, 1'b0, "ctrl rd");
    @(posedge clk); #1 mvu_done = 1'b1;
    @(posedge clk); #1 mvu_done = 1'b0;
    @(negedge clk);
    check("irq after done", {31'b0, irq}, 32'h1);
    apb(1'b0, 12'h004, 32'h0, 32'h2, 1'b0, "status done");
    apb(1'b1, 12'h004, 32'h2, 32'h0, 1'b0, "status w1c");
    @(negedge clk);
    check("irq after w1c", {31'b0, irq}, 32'h0);
    apb(1'b0, 12'h004, 32'h0, 32'h0, 1'b0, "status clr");

    // start while busy: refused, other CTRL bits still land
    mvu_busy = 1'b1;
    apb(1'b1, 12'h000, 32'h3, 32'h0, 1'b1, "busy start");
    @(negedge clk);
    check("busy no start", {31'b0, cfg_start}, 32'h0);
    @(negedge clk);
    check("busy no start2", {31'b0, cfg_start}, 32'h0);
    mvu_busy = 1'b0;
    apb(1'b0, 12'h000, 32'h0, 32'h2, 1'b0, "ctrl after busy");
    check("relu cleared", {31'b0, cfg_relu_en}, 32'h0);

    // completion and W1C clear on the same edge: set wins
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'h2;
    @(posedge clk); #1;
    penable = 1'b1; mvu_done = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; mvu_done = 1'b0;
    @(negedge clk);
    check("set wins irq", {31'b0, irq}, 32'h1);
    apb(1'b0, 12'h004, 32'h0, 32'h2, 1'b0, "set wins status");

    // a new start leaves done alone
    apb(1'b1, 12'h000, 32'h3, 32'h0, 1'b0, "restart");
    @(negedge clk);
    check("restart pulse", {31'b0, cfg_start}, 32'h1);
    apb(1'b0, 12'h004, 32'h0, 32'h2, 1'b0, "done kept");

    // reset asserted during an access phase beats the write and mvu_done
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h014; pwdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    penable = 1'b1; rst = 1'b1; mvu_done = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rst = 1'b0; mvu_done = 1'b0;
    @(negedge clk);
    check("rst wbase",     cfg_wbase,              32'h0);
    check("rst countdown", cfg_countdown,          32'h0);
    check("rst wprec",     {26'b0, cfg_wprec},     32'h0);
    check("rst irq",       {31'b0, irq},           32'h0);
    check("rst start",     {31'b0, cfg_start},     32'h0);
    for (int a = 0; a <= 'h24; a += 4)
      apb(1'b0, 12'(a), 32'h0, 32'h0, 1'b0, $sformatf("post-rst@%03h", a));
    apb(1'b0, 12'h028, 32'h0, ID_EXP, 1'b0, "post-rst id");

    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard drain: got %0d entries expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
